// File: rtl/uart_tx_framer_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_framer_pkg
// Shared definitions for the UART TX packet framer:
//   - byte width and FIFO entry layout ({last, data}, 9 bits)
//   - framer state encodings
//   - request-pulse bundle and a decode helper from state to request
// -----------------------------------------------------------------------------
package uart_tx_framer_pkg;

  localparam int DATA_W  = 8;
  localparam int ENTRY_W = DATA_W + 1;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SEND_START = 3'd1,
    ST_SEND_DATA  = 3'd2,
    ST_SEND_END   = 3'd3,
    ST_SEND_VSYNC = 3'd4,
    ST_SEND_INT   = 3'd5,
    ST_WAIT_ACK   = 3'd6,
    ST_WAIT_DONE  = 3'd7
  } state_t;

  // One bit per encoder request line.
  typedef struct packed {
    logic start;
    logic data;
    logic finish;
    logic vsync;
    logic irq;
  } req_t;

  // Each SEND_x state owns exactly one request line; all other states own none.
  function automatic req_t req_for(state_t s);
    req_t r;
    r = '0;
    case (s)
      ST_SEND_START: r.start  = 1'b1;
      ST_SEND_DATA:  r.data   = 1'b1;
      ST_SEND_END:   r.finish = 1'b1;
      ST_SEND_VSYNC: r.vsync  = 1'b1;
      ST_SEND_INT:   r.irq    = 1'b1;
      default:       r        = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous FIFO with show-ahead read port (head entry always visible).
//   i_master_clk  system clock
//   i_reset       asynchronous active-high reset (pointers/count only)
//   i_wr_en       push request; ignored while o_full
//   i_wr_data     entry to push
//   i_rd_en       pop request; ignored while o_empty
//   o_rd_data     current head entry
//   o_full        DEPTH entries held
//   o_empty       no entries held
//   o_level       occupancy, 0..DEPTH
// Full is evaluated on the pre-edge occupancy, so a push while full is
// rejected even when a pop happens on the same edge.
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter  int DEPTH   = 16,
  parameter  int WIDTH   = 9,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int LEVEL_W = PTR_W + 1
) (
  input  logic               i_master_clk,
  input  logic               i_reset,
  input  logic               i_wr_en,
  input  logic [WIDTH-1:0]   i_wr_data,
  input  logic               i_rd_en,
  output logic [WIDTH-1:0]   o_rd_data,
  output logic               o_full,
  output logic               o_empty,
  output logic [LEVEL_W-1:0] o_level
);

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [LEVEL_W-1:0] count;
  logic               push;
  logic               pop;

  assign o_full    = (count == LEVEL_W'(DEPTH));
  assign o_empty   = (count == '0);
  assign o_level   = count;
  assign push      = i_wr_en && !o_full;
  assign pop       = i_rd_en && !o_empty;
  assign o_rd_data = mem[rd_ptr];

  // NOTE: storage is deliberately left out of reset; validity is defined by
  // the pointers and count, and a resettable array would cost a mux per bit.
  always_ff @(posedge i_master_clk) begin
    if (push) mem[wr_ptr] <= i_wr_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge i_master_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + LEVEL_W'(1);
        2'b01:   count <= count - LEVEL_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_framer.sv
// -----------------------------------------------------------------------------
// uart_tx_framer
// Packet framer in front of the UART TX encoder. Bytes are queued with an
// end-of-packet mark; each packet goes out as start, one data request per
// byte, end. VSYNC / interrupt events are held pending and only inserted
// between packets.
//   i_master_clk            system clock
//   i_reset                 asynchronous active-high reset
//   i_wr_data/i_wr_last     byte to queue and its end-of-packet mark
//   i_wr_valid              write strobe
//   o_wr_full               FIFO full, writes rejected
//   o_overflow              one-cycle pulse after a rejected write
//   o_level                 FIFO occupancy
//   i_vsync/i_interrupt     event pulses
//   o_tx_data               byte presented to the encoder
//   o_tx_*_request          one-cycle registered request pulses
//   i_tx_busy               encoder busy
//   o_in_packet             start sent, end not yet sent
// -----------------------------------------------------------------------------
module uart_tx_framer
  import uart_tx_framer_pkg::*;
#(
  parameter  int FIFO_DEPTH = 16,
  localparam int LEVEL_W    = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               i_master_clk,
  input  logic               i_reset,
  input  logic [7:0]         i_wr_data,
  input  logic               i_wr_last,
  input  logic               i_wr_valid,
  output logic               o_wr_full,
  output logic               o_overflow,
  output logic [LEVEL_W-1:0] o_level,
  input  logic               i_vsync,
  input  logic               i_interrupt,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_data_request,
  output logic               o_tx_start_request,
  output logic               o_tx_end_request,
  output logic               o_tx_vsync_request,
  output logic               o_tx_interrupt_request,
  input  logic               i_tx_busy,
  output logic               o_in_packet
);

  state_t      state_q;
  state_t      state_d;
  state_t      r_sent;      // last SEND_x state visited; selects the WAIT_DONE exit
  logic        r_last;      // end mark of the byte currently in o_tx_data
  logic        p_vsync;
  logic        p_int;
  logic        fifo_empty;
  fifo_entry_t fifo_head;
  fifo_entry_t wr_entry;

  req_t        req_d;
  logic        pop;
  logic        clr_vsync;
  logic        clr_int;
  logic        in_packet_d;

  assign wr_entry = '{last: i_wr_last, data: i_wr_data};

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .i_master_clk (i_master_clk),
    .i_reset      (i_reset),
    .i_wr_en      (i_wr_valid),
    .i_wr_data    (wr_entry),
    .i_rd_en      (pop),
    .o_rd_data    (fifo_head),
    .o_full       (o_wr_full),
    .o_empty      (fifo_empty),
    .o_level      (o_level)
  );

  // State register.
  always_ff @(posedge i_master_clk or posedge i_reset) begin
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic. Events are only considered in IDLE, so a packet that
  // underruns mid-way stalls in WAIT_DONE without ever servicing an event.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!i_tx_busy) begin
          if (p_vsync)          state_d = ST_SEND_VSYNC;
          else if (p_int)       state_d = ST_SEND_INT;
          else if (!fifo_empty) state_d = ST_SEND_START;
        end
      end
      ST_SEND_START,
      ST_SEND_DATA,
      ST_SEND_END,
      ST_SEND_VSYNC,
      ST_SEND_INT:              state_d = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (i_tx_busy)          state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (!i_tx_busy) begin
          case (r_sent)
            ST_SEND_START: begin
              if (!fifo_empty)  state_d = ST_SEND_DATA;
            end
            ST_SEND_DATA: begin
              if (r_last)           state_d = ST_SEND_END;
              else if (!fifo_empty) state_d = ST_SEND_DATA;
            end
            default:            state_d = ST_IDLE;
          endcase
        end
      end
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Output decode: values to be registered on the edge entering state_d, so
  // every request line is high exactly while its SEND_x state is current.
  always_comb begin
    req_d       = req_for(state_d);
    pop         = (state_d == ST_SEND_DATA);
    clr_vsync   = (state_d == ST_SEND_VSYNC);
    clr_int     = (state_d == ST_SEND_INT);
    in_packet_d = o_in_packet;
    if (state_d == ST_SEND_START)
      in_packet_d = 1'b1;
    else if (state_q == ST_WAIT_DONE && state_d == ST_IDLE && r_sent == ST_SEND_END)
      in_packet_d = 1'b0;
  end

  // Registered outputs, pending flags and datapath.
  always_ff @(posedge i_master_clk or posedge i_reset) begin
    if (i_reset) begin
      o_tx_start_request     <= 1'b0;
      o_tx_data_request      <= 1'b0;
      o_tx_end_request       <= 1'b0;
      o_tx_vsync_request     <= 1'b0;
      o_tx_interrupt_request <= 1'b0;
      o_tx_data              <= '0;
      o_in_packet            <= 1'b0;
      o_overflow             <= 1'b0;
      r_last                 <= 1'b0;
      r_sent                 <= ST_IDLE;
      p_vsync                <= 1'b0;
      p_int                  <= 1'b0;
    end else begin
      o_tx_start_request     <= req_d.start;
      o_tx_data_request      <= req_d.data;
      o_tx_end_request       <= req_d.finish;
      o_tx_vsync_request     <= req_d.vsync;
      o_tx_interrupt_request <= req_d.irq;
      o_in_packet            <= in_packet_d;
      o_overflow             <= i_wr_valid && o_wr_full;
      if (pop) begin
        o_tx_data <= fifo_head.data;
        r_last    <= fifo_head.last;
      end
      if (req_d != '0) r_sent <= state_d;
      // A pulse on the issuing edge re-arms the flag for a second request.
      p_vsync <= (p_vsync && !clr_vsync) || i_vsync;
      p_int   <= (p_int   && !clr_int)   || i_interrupt;
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_framer
// Directed bench for uart_tx_framer. A small encoder model raises busy the
// cycle after any request and holds it for busy_len cycles; busy_force holds
// busy high independently. A monitor logs every request (kind + data byte)
// and checks that requests are one-hot and never in consecutive cycles.
// -----------------------------------------------------------------------------
module tb_uart_tx_framer;

  logic       i_master_clk;
  logic       i_reset;
  logic [7:0] i_wr_data;
  logic       i_wr_last;
  logic       i_wr_valid;
  logic       o_wr_full;
  logic       o_overflow;
  logic [4:0] o_level;
  logic       i_vsync;
  logic       i_interrupt;
  logic [7:0] o_tx_data;
  logic       o_tx_data_request;
  logic       o_tx_start_request;
  logic       o_tx_end_request;
  logic       o_tx_vsync_request;
  logic       o_tx_interrupt_request;
  logic       i_tx_busy;
  logic       o_in_packet;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_framer dut (
    .i_master_clk           (i_master_clk),
    .i_reset                (i_reset),
    .i_wr_data              (i_wr_data),
    .i_wr_last              (i_wr_last),
    .i_wr_valid             (i_wr_valid),
    .o_wr_full              (o_wr_full),
    .o_overflow             (o_overflow),
    .o_level                (o_level),
    .i_vsync                (i_vsync),
    .i_interrupt            (i_interrupt),
    .o_tx_data              (o_tx_data),
    .o_tx_data_request      (o_tx_data_request),
    .o_tx_start_request     (o_tx_start_request),
    .o_tx_end_request       (o_tx_end_request),
    .o_tx_vsync_request     (o_tx_vsync_request),
    .o_tx_interrupt_request (o_tx_interrupt_request),
    .i_tx_busy              (i_tx_busy),
    .o_in_packet            (o_in_packet)
  );

  initial i_master_clk = 1'b0;
  always #5 i_master_clk = ~i_master_clk;

  // Encoder model.
  logic       busy_force;
  int         busy_len;
  int         busy_cnt;
  logic [4:0] req_vec;

  assign req_vec = {o_tx_start_request, o_tx_data_request, o_tx_end_request,
                    o_tx_vsync_request, o_tx_interrupt_request};
  assign i_tx_busy = busy_force || (busy_cnt != 0);

  initial busy_cnt = 0;
  always @(posedge i_master_clk) begin
    if (req_vec != 5'b0)   busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Request monitor.
  byte        log_kind[$];
  logic [7:0] log_data[$];
  logic       prev_any;
  int         ovf_cnt;

  initial begin
    prev_any = 1'b0;
    ovf_cnt  = 0;
  end

  always @(negedge i_master_clk) begin
    if (req_vec != 5'b0) begin
      check("req_onehot", 32'($countones(req_vec)), 32'd1);
      check("req_gap", {31'b0, prev_any}, 32'd0);
      if (o_tx_start_request)     begin log_kind.push_back("S"); log_data.push_back(8'h00);     end
      if (o_tx_data_request)      begin log_kind.push_back("D"); log_data.push_back(o_tx_data); end
      if (o_tx_end_request)       begin log_kind.push_back("E"); log_data.push_back(8'h00);     end
      if (o_tx_vsync_request)     begin log_kind.push_back("V"); log_data.push_back(8'h00);     end
      if (o_tx_interrupt_request) begin log_kind.push_back("I"); log_data.push_back(8'h00);     end
    end
    if (o_overflow) ovf_cnt++;
    prev_any = (req_vec != 5'b0);
  end

  task automatic clear_log();
    log_kind.delete();
    log_data.delete();
  endtask

  task automatic write_byte(input logic [7:0] d, input logic last);
    i_wr_data  = d;
    i_wr_last  = last;
    i_wr_valid = 1'b1;
    @(negedge i_master_clk);
    i_wr_valid = 1'b0;
    i_wr_last  = 1'b0;
  endtask

  task automatic pulse_events(input logic vs, input logic irq);
    i_vsync     = vs;
    i_interrupt = irq;
    @(negedge i_master_clk);
    i_vsync     = 1'b0;
    i_interrupt = 1'b0;
  endtask

  task automatic wait_log(input int n, input int budget);
    int k;
    k = 0;
    while (log_kind.size() < n && k < budget) begin
      @(negedge i_master_clk);
      k++;
    end
    check("log_reach", 32'(log_kind.size()), 32'(n));
  endtask

  task automatic check_kind(input string tag, input int idx, input byte k);
    byte got;
    got = (idx < log_kind.size()) ? log_kind[idx] : 8'h00;
    check(tag, {24'b0, got}, {24'b0, k});
  endtask

  task automatic check_data(input string tag, input int idx, input logic [7:0] d);
    logic [7:0] got;
    got = (idx < log_data.size()) ? log_data[idx] : 8'hxx;
    check(tag, {24'b0, got}, {24'b0, d});
  endtask

  initial begin
    i_reset     = 1'b1;
    i_wr_data   = 8'h00;
    i_wr_last   = 1'b0;
    i_wr_valid  = 1'b0;
    i_vsync     = 1'b0;
    i_interrupt = 1'b0;
    busy_force  = 1'b0;
    busy_len    = 20;
    repeat (3) @(negedge i_master_clk);

    // Reset state.
    check("rst_req", {27'b0, req_vec}, 32'd0);
    check("rst_level", {27'b0, o_level}, 32'd0);
    check("rst_full", {31'b0, o_wr_full}, 32'd0);
    check("rst_ovf", {31'b0, o_overflow}, 32'd0);
    check("rst_inpkt", {31'b0, o_in_packet}, 32'd0);
    check("rst_data", {24'b0, o_tx_data}, 32'd0);
    i_reset = 1'b0;
    @(negedge i_master_clk);

    // Two-byte packet: start one cycle after the edge following the write.
    clear_log();
    write_byte(8'h3C, 1'b0);
    check("t1_level1", {27'b0, o_level}, 32'd1);
    check("t1_nostart", {31'b0, o_tx_start_request}, 32'd0);
    write_byte(8'hA5, 1'b1);
    check("t1_start", {31'b0, o_tx_start_request}, 32'd1);
    check("t1_inpkt1", {31'b0, o_in_packet}, 32'd1);
    check("t1_level2", {27'b0, o_level}, 32'd2);
    wait_log(4, 300);
    check_kind("t1_k0", 0, "S");
    check_kind("t1_k1", 1, "D");
    check_data("t1_d1", 1, 8'h3C);
    check_kind("t1_k2", 2, "D");
    check_data("t1_d2", 2, 8'hA5);
    check_kind("t1_k3", 3, "E");
    repeat (30) @(negedge i_master_clk);
    check("t1_count", 32'(log_kind.size()), 32'd4);
    check("t1_inpkt0", {31'b0, o_in_packet}, 32'd0);
    check("t1_hold", {24'b0, o_tx_data}, 32'hA5);
    check("t1_level0", {27'b0, o_level}, 32'd0);

    // VSYNC during byte 2 of a 4-byte packet is deferred past the end.
    clear_log();
    write_byte(8'h01, 1'b0);
    write_byte(8'h02, 1'b0);
    write_byte(8'h03, 1'b0);
    write_byte(8'h04, 1'b1);
    wait_log(3, 300);
    pulse_events(1'b1, 1'b0);
    wait_log(7, 400);
    check_data("t2_d4", 4, 8'h04);
    check_kind("t2_k5", 5, "E");
    check_kind("t2_k6", 6, "V");
    repeat (40) @(negedge i_master_clk);

    // Simultaneous events in IDLE: vsync wins, interrupt follows.
    clear_log();
    pulse_events(1'b1, 1'b1);
    wait_log(2, 200);
    check_kind("t2b_k0", 0, "V");
    check_kind("t2b_k1", 1, "I");
    repeat (40) @(negedge i_master_clk);

    // Repeated vsync pulses while pending coalesce.
    clear_log();
    busy_force = 1'b1;
    pulse_events(1'b1, 1'b0);
    repeat (5) @(negedge i_master_clk);
    pulse_events(1'b1, 1'b0);
    repeat (5) @(negedge i_master_clk);
    pulse_events(1'b1, 1'b0);
    repeat (5) @(negedge i_master_clk);
    check("t3_held", 32'(log_kind.size()), 32'd0);
    busy_force = 1'b0;
    repeat (60) @(negedge i_master_clk);
    check("t3_count", 32'(log_kind.size()), 32'd1);
    check_kind("t3_k0", 0, "V");

    // Overflow: 17 writes into 16 entries while the encoder is busy.
    clear_log();
    ovf_cnt    = 0;
    busy_force = 1'b1;
    for (int i = 0; i < 17; i++) begin
      write_byte((i == 16) ? 8'hFF : 8'(8'h40 + i), (i >= 15));
    end
    check("t4_ovf_pulse", {31'b0, o_overflow}, 32'd1);
    check("t4_level16", {27'b0, o_level}, 32'd16);
    check("t4_full", {31'b0, o_wr_full}, 32'd1);
    @(negedge i_master_clk);
    check("t4_ovf_drop", {31'b0, o_overflow}, 32'd0);
    check("t4_ovf_cnt", 32'(ovf_cnt), 32'd1);
    busy_force = 1'b0;
    wait_log(18, 1000);
    check_data("t4_d_first", 1, 8'h40);
    check_data("t4_d_last", 16, 8'h4F);
    check_kind("t4_k17", 17, "E");
    repeat (40) @(negedge i_master_clk);
    check("t4_count", 32'(log_kind.size()), 32'd18);
    check("t4_level0", {27'b0, o_level}, 32'd0);
    check("t4_notfull", {31'b0, o_wr_full}, 32'd0);

    // Mid-packet underrun: stall in WAIT_DONE, event held until after end.
    clear_log();
    write_byte(8'h11, 1'b0);
    repeat (30) @(negedge i_master_clk);
    pulse_events(1'b0, 1'b1);
    repeat (50) @(negedge i_master_clk);
    check("t5_stall_count", 32'(log_kind.size()), 32'd2);
    check_data("t5_d1", 1, 8'h11);
    check("t5_inpkt", {31'b0, o_in_packet}, 32'd1);
    check("t5_data_hold", {24'b0, o_tx_data}, 32'h11);
    write_byte(8'h22, 1'b1);
    wait_log(5, 300);
    check_kind("t5_k2", 2, "D");
    check_data("t5_d2", 2, 8'h22);
    check_kind("t5_k3", 3, "E");
    check_kind("t5_k4", 4, "I");
    repeat (40) @(negedge i_master_clk);

    // Reset mid-packet with the encoder busy.
    clear_log();
    write_byte(8'h55, 1'b0);
    write_byte(8'h66, 1'b1);
    wait_log(2, 200);
    busy_force = 1'b1;
    repeat (3) @(negedge i_master_clk);
    i_reset = 1'b1;
    #1;
    check("t6_rst_req", {27'b0, req_vec}, 32'd0);
    check("t6_rst_inpkt", {31'b0, o_in_packet}, 32'd0);
    check("t6_rst_level", {27'b0, o_level}, 32'd0);
    check("t6_rst_data", {24'b0, o_tx_data}, 32'd0);
    @(negedge i_master_clk);
    i_reset = 1'b0;
    clear_log();
    write_byte(8'h77, 1'b1);
    repeat (20) @(negedge i_master_clk);
    check("t6_wait_busy", 32'(log_kind.size()), 32'd0);
    check("t6_level1", {27'b0, o_level}, 32'd1);
    busy_force = 1'b0;
    wait_log(3, 300);
    check_kind("t6_k0", 0, "S");
    check_data("t6_d1", 1, 8'h77);
    check_kind("t6_k2", 2, "E");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
